// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (start, LSB-first data, optional parity, 1-2 stop bits); define UART_TX_HOLD_EN for a one-word holding register
module uart_tx_param #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] d_tx,
  input  logic                 vld_tx,
  output logic                 rdy_tx,
  output logic                 txd,
  output logic                 busy
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int CW = $clog2(DATA_BITS + 2);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  logic [2:0] state, state_n;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_BITS-1:0] sh, sh_n, ld_d;
  logic par, par_n, tick, done, acc, ld, last;
  assign tick = div == DW'(CLK_DIV - 1);
  assign done = state == S_STOP && tick && cnt == CW'(STOP_BITS - 1);
  assign last = cnt == CW'(DATA_BITS - 1);
  assign acc  = vld_tx & rdy_tx;
  assign busy = state != S_IDLE;
  assign par_n = ld ? ((PARITY == 1) ? ~^ld_d : ^ld_d) : par;
`ifdef UART_TX_HOLD_EN
  logic hv;
  logic [DATA_BITS-1:0] hd;
  assign rdy_tx = !hv;
  assign ld = (state == S_IDLE && acc) || (done && (hv || acc));
  assign ld_d = hv ? hd : d_tx;
  // holding register: filled by a handshake that cannot go straight to the shifter, drained at frame end
  always_ff @(posedge clk) begin
    hv <= rst ? 1'b0 : (done && hv) ? 1'b0 : (acc && !ld) ? 1'b1 : hv;
    hd <= rst ? '0 : (acc && !ld) ? d_tx : hd;
  end
`else
  assign rdy_tx = state == S_IDLE;
  assign ld = acc;
  assign ld_d = d_tx;
`endif
  // next-state: a load always restarts at START, otherwise advance on bit boundaries
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    if (ld) begin
      state_n = S_START;
      cnt_n = '0;
      sh_n = ld_d;
    end else if (tick) begin
      case (state)
        S_START: begin
          state_n = S_DATA;
          cnt_n = '0;
        end
        S_DATA: begin
          sh_n = sh >> 1;
          state_n = last ? ((PARITY != 0) ? S_PAR : S_STOP) : S_DATA;
          cnt_n = last ? '0 : cnt + 1'b1;
        end
        S_PAR: begin
          state_n = S_STOP;
          cnt_n = '0;
        end
        S_STOP: begin
          state_n = done ? S_IDLE : S_STOP;
          cnt_n = done ? '0 : cnt + 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end
  // state registers; txd is registered from the next state so it changes together with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      div <= '0;
      cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      txd <= 1'b1;
    end else begin
      state <= state_n;
      div <= (state == S_IDLE || tick) ? '0 : div + 1'b1;
      cnt <= cnt_n;
      sh <= sh_n;
      par <= par_n;
      txd <= (state_n == S_START) ? 1'b0 : (state_n == S_DATA) ? sh_n[0] : (state_n == S_PAR) ? par_n : 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: randomized self-checking bench for uart_tx_param against a bit-list frame model
module tb_uart_tx_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] vld = '0;
  logic [3:0] rdy, txd, busy;
  logic [8:0] d [4];
  int n_cmp = 0;
  int n_bad = 0;
  logic exp_q[$];
  localparam int CD [4] = '{4, 4, 4, 3};
  localparam int DB [4] = '{8, 8, 8, 7};
  localparam int PM [4] = '{0, 2, 1, 0};
  localparam int SB [4] = '{1, 1, 1, 2};
`ifdef UART_TX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .d_tx(d[0][7:0]), .vld_tx(vld[0]), .rdy_tx(rdy[0]), .txd(txd[0]), .busy(busy[0]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .d_tx(d[1][7:0]), .vld_tx(vld[1]), .rdy_tx(rdy[1]), .txd(txd[1]), .busy(busy[1]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .d_tx(d[2][7:0]), .vld_tx(vld[2]), .rdy_tx(rdy[2]), .txd(txd[2]), .busy(busy[2]));
  uart_tx_param #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .d_tx(d[3][6:0]), .vld_tx(vld[3]), .rdy_tx(rdy[3]), .txd(txd[3]), .busy(busy[3]));
  task automatic add_frame(input int k, input logic [8:0] w);
    int ones;
    logic bits[$];
    ones = 0;
    bits.push_back(1'b0);
    for (int b = 0; b < DB[k]; b++) begin
      bits.push_back(w[b]);
      ones += int'(w[b]);
    end
    if (PM[k] == 1) bits.push_back(ones % 2 == 0);
    else if (PM[k] == 2) bits.push_back(ones % 2 == 1);
    repeat (SB[k]) bits.push_back(1'b1);
    foreach (bits[i]) repeat (CD[k]) exp_q.push_back(bits[i]);
  endtask
  task automatic frame(input int k, input logic [8:0] w);
    exp_q = {};
    add_frame(k, w);
    @(negedge clk);
    n_cmp++;
    if (rdy[k] !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_ready dut%0d: got %b want 1", k, rdy[k]);
    end
    d[k] = w;
    vld[k] = 1'b1;
    @(negedge clk);
    vld[k] = 1'b0;
    d[k] = 9'($urandom);
    foreach (exp_q[i]) begin
      n_cmp++;
      if ({txd[k], rdy[k], busy[k]} !== {exp_q[i], HOLD, 1'b1}) begin
        n_bad++;
        $display("FAIL frame dut%0d word %h cycle %0d txd/rdy/busy: got %b%b%b want %b%b1",
                 k, w, i, txd[k], rdy[k], busy[k], exp_q[i], HOLD);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({txd[k], rdy[k], busy[k]} !== 3'b110) begin
      n_bad++;
      $display("FAIL frame_end dut%0d txd/rdy/busy: got %b%b%b want 110", k, txd[k], rdy[k], busy[k]);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({txd, rdy, busy} !== 12'hFF0) begin
      n_bad++;
      $display("FAIL reset_hold txd/rdy/busy: got %h want ff0", {txd, rdy, busy});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({txd, rdy, busy} !== 12'hFF0) begin
      n_bad++;
      $display("FAIL reset_release txd/rdy/busy: got %h want ff0", {txd, rdy, busy});
    end
  endtask
  task automatic test_basic();
    frame(0, 9'h0A5);
    frame(0, 9'h000);
    frame(0, 9'h0FF);
  endtask
  task automatic test_parity();
    frame(1, 9'h007);
    frame(2, 9'h007);
    frame(1, 9'h000);
    frame(2, 9'h000);
  endtask
  task automatic test_stop_width();
    frame(3, 9'h055);
    frame(3, 9'h07F);
  endtask
  task automatic test_busy_input();
    int n;
    logic exp_r;
    exp_q = {};
    n = 10 * CD[0];
    @(negedge clk);
    d[0] = 9'($urandom_range(0, 255));
    vld[0] = 1'b1;
    add_frame(0, d[0]);
    exp_q.push_back(1'b1);
    for (int s = 1; s <= 2 * n + 1; s++) begin
      @(negedge clk);
      exp_r = (s == n + 1);
      n_cmp++;
      if ({txd[0], rdy[0]} !== {exp_q[s-1], exp_r}) begin
        n_bad++;
        $display("FAIL busy_input sample %0d txd/rdy: got %b%b want %b%b", s, txd[0], rdy[0], exp_q[s-1], exp_r);
      end
      d[0] = 9'($urandom_range(0, 255));
      if (s == n + 1) add_frame(0, d[0]);
    end
    vld[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({txd[0], rdy[0], busy[0]} !== 3'b110) begin
      n_bad++;
      $display("FAIL busy_input_end txd/rdy/busy: got %b%b%b want 110", txd[0], rdy[0], busy[0]);
    end
  endtask
  task automatic test_hold(input logic [8:0] w0, input logic [8:0] w1);
    logic exp_r;
    exp_q = {};
    add_frame(0, w0);
    add_frame(0, w1);
    @(negedge clk);
    d[0] = w0;
    vld[0] = 1'b1;
    for (int s = 1; s <= 80; s++) begin
      @(negedge clk);
      exp_r = !(s >= 2 && s <= 40);
      n_cmp++;
      if ({txd[0], rdy[0], busy[0]} !== {exp_q[s-1], exp_r, 1'b1}) begin
        n_bad++;
        $display("FAIL hold sample %0d txd/rdy/busy: got %b%b%b want %b%b1", s, txd[0], rdy[0], busy[0], exp_q[s-1], exp_r);
      end
      if (s == 1) d[0] = w1;
      if (s == 2) vld[0] = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if ({txd[0], rdy[0], busy[0]} !== 3'b110) begin
      n_bad++;
      $display("FAIL hold_end txd/rdy/busy: got %b%b%b want 110", txd[0], rdy[0], busy[0]);
    end
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    d[0] = 9'($urandom_range(0, 255));
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({txd[0], rdy[0], busy[0]} !== 3'b110) begin
      n_bad++;
      $display("FAIL reset_mid txd/rdy/busy: got %b%b%b want 110", txd[0], rdy[0], busy[0]);
    end
    frame(0, 9'h03C);
  endtask
  task automatic test_random();
    for (int k = 0; k < 4; k++)
      repeat (3) frame(k, 9'($urandom_range(0, (1 << DB[k]) - 1)));
  endtask
  initial begin
    foreach (d[i]) d[i] = '0;
    test_reset();
    test_basic();
    test_parity();
    test_stop_width();
`ifdef UART_TX_HOLD_EN
    test_hold(9'h011, 9'h022);
    test_hold(9'($urandom_range(0, 255)), 9'($urandom_range(0, 255)));
`else
    test_busy_input();
`endif
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. Serialises one DATA_BITS-wide word per valid/ready handshake into a standard asynchronous frame: start bit, data LSB-first, optional parity bit, then 1 or 2 stop bits. Runs on the system clock with an internal bit-period divider, so no baud-rate clock domain is needed. Sits between a byte-producing controller and the board TX pin.

Parameters:
CLK_DIV, 16, system clocks per bit period; legal range is 2 or more.
DATA_BITS, 8, data bits per frame; legal range is 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  reset, synchronous, active-high.
d_tx  input  DATA_BITS  word to send; sampled only on the handshake edge.
vld_tx  input  1  producer asserts when d_tx is valid.
rdy_tx  output  1  block can accept a word this cycle.
txd  output  1  serial line; idles high; registered output.
busy  output  1  a frame is in progress (state is not IDLE).

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, txd=1, rdy_tx=1, busy=0. Divider, bit counter and shift register are cleared. Reset mid-frame aborts the frame: txd is 1 from the next cycle, and the partial frame is not resumed.
- Handshake: a word is accepted at a posedge where vld_tx & rdy_tx = 1. At that same edge d_tx is loaded into the shift register, parity is computed from d_tx, rdy_tx goes to 0 and state goes to START.
- vld_tx while rdy_tx=0 is ignored. Changes on d_tx after acceptance have no effect.
- States:
  - IDLE: txd=1.
  - START: txd=0.
  - DATA: txd = shift register bit 0. The register shifts right at the end of each bit.
  - PARITY: entered only if PARITY is not 0. Odd mode sends the complement of the XOR of the data bits; even mode sends the XOR of the data bits.
  - STOP: txd=1, lasts STOP_BITS bit periods.
- Bit timing: every non-IDLE bit lasts exactly CLK_DIV cycles.
  - The divider counts 0..CLK_DIV-1 and wraps to 0 on each bit boundary.
  - The bit counter counts DATA_BITS data bits, then STOP_BITS stop bits.
- Latency: txd falls on the first cycle after the handshake edge.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV cycles.
- End of frame: at the edge that completes the last stop bit, state goes to IDLE and rdy_tx goes to 1.
  - A new handshake is possible from the following edge.
  - Without the hold feature, back-to-back frames are therefore separated by at least 1 extra idle-high cycle.
- Counter widths: $clog2(CLK_DIV) for the divider and $clog2(DATA_BITS+2) for the bit counter. There is no overflow; wrap is explicit.
- Simultaneous events: rst has priority over the handshake and over any state transition.

Optional Feature:
Macro UART_TX_HOLD_EN.
- When defined: adds a 1-entry holding register with a valid flag.
  - rdy_tx = 1 whenever the holding register is empty, including during a frame.
  - A handshake while the block is busy writes the holding register.
  - At the edge completing the last stop bit, if the holding register is full, its content moves to the shift register, state goes directly to START and the register empties. There is zero idle gap between frames.
  - A handshake in IDLE with the holding register empty loads the shift register directly.
  - Reset clears the holding register.
- When undefined: rdy_tx = 1 only in IDLE. Behaviour is exactly as in Behaviour.

Test Plan:
- Basic frame (CLK_DIV=4, DATA_BITS=8, PARITY=0, STOP_BITS=1): send 0xA5. txd, 4 cycles per bit, is 0,1,0,1,0,0,1,0,1,1. rdy_tx stays low for exactly 40 cycles after the handshake edge, then returns to 1.
- Parity (CLK_DIV=4, DATA_BITS=8):
  - PARITY=2 with 0x07 gives a parity bit of 1.
  - PARITY=1 with 0x07 gives a parity bit of 0.
  - The frame is 11 bits = 44 cycles.
- Stop and width (STOP_BITS=2, DATA_BITS=7, CLK_DIV=3): send 0x55. Frame is 0,1,0,1,0,1,0,1,1,1 with 3 cycles per bit, 30 cycles total; the stop level stays high for 6 cycles.
- Busy-time input (defaults, hold feature off): with vld_tx=1 and d_tx toggling during a frame, only the first word is sent. The next word is accepted exactly 1 cycle after rdy_tx returns high, giving txd ≥ CLK_DIV+1 high cycles between frames.
- Reset mid-frame (CLK_DIV=4): assert rst for 1 cycle during data bit 3. Next cycle txd=1, rdy_tx=1, busy=0. A fresh frame for 0x3C is then sent correctly.
- With UART_TX_HOLD_EN (CLK_DIV=4): hand over 0x11 then 0x22 on consecutive accepted cycles. The two frames are contiguous: second start bit immediately after first stop bit, 80 cycles total. rdy_tx is low only while the holding register is full.
